// File: rtl/rggen_rtl_pkg.sv
// Shared helpers, widths and payload layouts for the rggen AXI4-Lite
// channel buffer and its FIFOs.
package rggen_rtl_pkg;
  localparam int RGGEN_AXI4LITE_MAX_BUFFER_DEPTH = 8;

  localparam int RGGEN_AXI4LITE_PAYLOAD_ID_WIDTH      = 1;
  localparam int RGGEN_AXI4LITE_PAYLOAD_ADDRESS_WIDTH = 8;
  localparam int RGGEN_AXI4LITE_PAYLOAD_BUS_WIDTH     = 32;

  function automatic int rggen_clip_width(input int width);
    return (width > 0) ? width : 1;
  endfunction

  // Flattened channel widths, used when the payload is parametrised per instance.
  function automatic int rggen_axi4lite_addr_payload_width(input int id_width, input int address_width);
    return rggen_clip_width(id_width) + address_width + 3;
  endfunction

  function automatic int rggen_axi4lite_w_payload_width(input int bus_width);
    return bus_width + (bus_width / 8);
  endfunction

  function automatic int rggen_axi4lite_b_payload_width(input int id_width);
    return rggen_clip_width(id_width) + 2;
  endfunction

  function automatic int rggen_axi4lite_r_payload_width(input int id_width, input int bus_width);
    return rggen_clip_width(id_width) + 2 + bus_width;
  endfunction

  typedef struct packed {
    logic [RGGEN_AXI4LITE_PAYLOAD_ID_WIDTH-1:0]      id;
    logic [RGGEN_AXI4LITE_PAYLOAD_ADDRESS_WIDTH-1:0] addr;
    logic [2:0]                                      prot;
  } rggen_axi4lite_aw_payload;

  typedef struct packed {
    logic [RGGEN_AXI4LITE_PAYLOAD_BUS_WIDTH-1:0]   data;
    logic [RGGEN_AXI4LITE_PAYLOAD_BUS_WIDTH/8-1:0] strb;
  } rggen_axi4lite_w_payload;

  typedef struct packed {
    logic [RGGEN_AXI4LITE_PAYLOAD_ID_WIDTH-1:0]      id;
    logic [RGGEN_AXI4LITE_PAYLOAD_ADDRESS_WIDTH-1:0] addr;
    logic [2:0]                                      prot;
  } rggen_axi4lite_ar_payload;

  typedef struct packed {
    logic [RGGEN_AXI4LITE_PAYLOAD_ID_WIDTH-1:0] id;
    logic [1:0]                                 resp;
  } rggen_axi4lite_b_payload;

  typedef struct packed {
    logic [RGGEN_AXI4LITE_PAYLOAD_ID_WIDTH-1:0]  id;
    logic [1:0]                                  resp;
    logic [RGGEN_AXI4LITE_PAYLOAD_BUS_WIDTH-1:0] data;
  } rggen_axi4lite_r_payload;
endpackage

// File: rtl/rggen_axi4lite_if.sv
// AXI4-Lite bundle with master/slave views; ID is carried as at least one bit.
interface rggen_axi4lite_if
  import rggen_rtl_pkg::*;
#(
  parameter int ID_WIDTH      = 0,
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);
  localparam int ID_W = rggen_clip_width(ID_WIDTH);

  logic                     awvalid;
  logic                     awready;
  logic [ID_W-1:0]          awid;
  logic [ADDRESS_WIDTH-1:0] awaddr;
  logic [2:0]               awprot;
  logic                     wvalid;
  logic                     wready;
  logic [BUS_WIDTH-1:0]     wdata;
  logic [BUS_WIDTH/8-1:0]   wstrb;
  logic                     bvalid;
  logic                     bready;
  logic [ID_W-1:0]          bid;
  logic [1:0]               bresp;
  logic                     arvalid;
  logic                     arready;
  logic [ID_W-1:0]          arid;
  logic [ADDRESS_WIDTH-1:0] araddr;
  logic [2:0]               arprot;
  logic                     rvalid;
  logic                     rready;
  logic [ID_W-1:0]          rid;
  logic [1:0]               rresp;
  logic [BUS_WIDTH-1:0]     rdata;

  modport master (
    output awvalid, awid, awaddr, awprot, input awready,
    output wvalid, wdata, wstrb, input wready,
    input bvalid, bid, bresp, output bready,
    output arvalid, arid, araddr, arprot, input arready,
    input rvalid, rid, rresp, rdata, output rready
  );

  modport slave (
    input awvalid, awid, awaddr, awprot, output awready,
    input wvalid, wdata, wstrb, output wready,
    output bvalid, bid, bresp, input bready,
    input arvalid, arid, araddr, arprot, output arready,
    output rvalid, rid, rresp, rdata, input rready
  );
endinterface

// File: rtl/rggen_axi4lite_channel_fifo.sv
// Registered valid/ready FIFO: ready and valid come only from the entry count,
// so neither side sees a combinational path from the other.
module rggen_axi4lite_channel_fifo
  import rggen_rtl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
)(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [WIDTH-1:0] storage_q [DEPTH];
  logic [WIDTH-1:0] storage_d [DEPTH];
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  assign o_ready = (count_q != FULL_COUNT);
  assign o_valid = (count_q != '0);
  assign o_empty = (count_q == '0);
  assign o_data  = storage_q[rd_ptr_q];
  assign push    = i_valid && o_ready;
  assign pop     = o_valid && i_ready;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = next_ptr(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    storage_d = storage_q;
    if (push) begin
      storage_d[wr_ptr_q] = i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload storage carries no reset; the count alone decides what is live.
  always_ff @(posedge i_clk) begin
    storage_q <= storage_d;
  end
endmodule

// File: rtl/rggen_axi4lite_channel_buffer.sv
// Decouples AW/W/AR through independent registered FIFOs. Defining
// RGGEN_AXI4LITE_RESPONSE_SLICE_EN also registers B and R; otherwise they pass through.
module rggen_axi4lite_channel_buffer
  import rggen_rtl_pkg::*;
#(
  parameter int ID_WIDTH      = 0,
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int DEPTH         = 2
)(
  input  logic            i_clk,
  input  logic            i_rst,
  rggen_axi4lite_if.slave  slave_if,
  rggen_axi4lite_if.master master_if,
  output logic            o_idle
);
  localparam int AW_W = rggen_axi4lite_addr_payload_width(ID_WIDTH, ADDRESS_WIDTH);
  localparam int W_W  = rggen_axi4lite_w_payload_width(BUS_WIDTH);
  localparam int AR_W = rggen_axi4lite_addr_payload_width(ID_WIDTH, ADDRESS_WIDTH);

  logic [AW_W-1:0] aw_data;
  logic [W_W-1:0]  w_data;
  logic [AR_W-1:0] ar_data;
  logic            aw_empty;
  logic            w_empty;
  logic            ar_empty;

  rggen_axi4lite_channel_fifo #(.WIDTH(AW_W), .DEPTH(DEPTH)) u_aw_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (slave_if.awvalid),
    .o_ready (slave_if.awready),
    .i_data  ({slave_if.awid, slave_if.awaddr, slave_if.awprot}),
    .o_valid (master_if.awvalid),
    .i_ready (master_if.awready),
    .o_data  (aw_data),
    .o_empty (aw_empty)
  );
  assign {master_if.awid, master_if.awaddr, master_if.awprot} = aw_data;

  rggen_axi4lite_channel_fifo #(.WIDTH(W_W), .DEPTH(DEPTH)) u_w_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (slave_if.wvalid),
    .o_ready (slave_if.wready),
    .i_data  ({slave_if.wdata, slave_if.wstrb}),
    .o_valid (master_if.wvalid),
    .i_ready (master_if.wready),
    .o_data  (w_data),
    .o_empty (w_empty)
  );
  assign {master_if.wdata, master_if.wstrb} = w_data;

  rggen_axi4lite_channel_fifo #(.WIDTH(AR_W), .DEPTH(DEPTH)) u_ar_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (slave_if.arvalid),
    .o_ready (slave_if.arready),
    .i_data  ({slave_if.arid, slave_if.araddr, slave_if.arprot}),
    .o_valid (master_if.arvalid),
    .i_ready (master_if.arready),
    .o_data  (ar_data),
    .o_empty (ar_empty)
  );
  assign {master_if.arid, master_if.araddr, master_if.arprot} = ar_data;

  assign o_idle = aw_empty && w_empty && ar_empty;

`ifdef RGGEN_AXI4LITE_RESPONSE_SLICE_EN
  localparam int B_W = rggen_axi4lite_b_payload_width(ID_WIDTH);
  localparam int R_W = rggen_axi4lite_r_payload_width(ID_WIDTH, BUS_WIDTH);

  logic [B_W-1:0] b_data;
  logic [R_W-1:0] r_data;
  logic           b_empty;
  logic           r_empty;
  logic           resp_empty_unused;

  // Two entries let the response slice accept a new beat every cycle.
  rggen_axi4lite_channel_fifo #(.WIDTH(B_W), .DEPTH(2)) u_b_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (master_if.bvalid),
    .o_ready (master_if.bready),
    .i_data  ({master_if.bid, master_if.bresp}),
    .o_valid (slave_if.bvalid),
    .i_ready (slave_if.bready),
    .o_data  (b_data),
    .o_empty (b_empty)
  );
  assign {slave_if.bid, slave_if.bresp} = b_data;

  rggen_axi4lite_channel_fifo #(.WIDTH(R_W), .DEPTH(2)) u_r_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (master_if.rvalid),
    .o_ready (master_if.rready),
    .i_data  ({master_if.rid, master_if.rresp, master_if.rdata}),
    .o_valid (slave_if.rvalid),
    .i_ready (slave_if.rready),
    .o_data  (r_data),
    .o_empty (r_empty)
  );
  assign {slave_if.rid, slave_if.rresp, slave_if.rdata} = r_data;

  assign resp_empty_unused = b_empty | r_empty;
`else
  assign slave_if.bvalid  = master_if.bvalid;
  assign master_if.bready = slave_if.bready;
  assign slave_if.bid     = master_if.bid;
  assign slave_if.bresp   = master_if.bresp;
  assign slave_if.rvalid  = master_if.rvalid;
  assign master_if.rready = slave_if.rready;
  assign slave_if.rid     = master_if.rid;
  assign slave_if.rresp   = master_if.rresp;
  assign slave_if.rdata   = master_if.rdata;
`endif
endmodule

// File: tb/tb_rggen_axi4lite_channel_buffer.sv
// Directed bench for rggen_axi4lite_channel_buffer with queue scoreboards on the request channels.
module tb_rggen_axi4lite_channel_buffer;
  logic clk;
  logic rst;
  logic idle2;
  logic idle3;
  int   n_vec;
  int   n_err;
  int   ar2_pops;
  int   w3_pops;
  int   idx;
  int   widx;
  logic acc;
  logic [7:0]  bp_addr [4];
  logic [63:0] q2_aw [$];
  logic [63:0] q2_ar [$];
  logic [63:0] q3_aw [$];
  logic [63:0] q3_w  [$];
  logic [63:0] q3_ar [$];

  rggen_axi4lite_if #(.ID_WIDTH(4), .ADDRESS_WIDTH(8), .BUS_WIDTH(32)) s2 ();
  rggen_axi4lite_if #(.ID_WIDTH(4), .ADDRESS_WIDTH(8), .BUS_WIDTH(32)) m2 ();
  rggen_axi4lite_if #(.ID_WIDTH(4), .ADDRESS_WIDTH(8), .BUS_WIDTH(32)) s3 ();
  rggen_axi4lite_if #(.ID_WIDTH(4), .ADDRESS_WIDTH(8), .BUS_WIDTH(32)) m3 ();

  rggen_axi4lite_channel_buffer #(.ID_WIDTH(4), .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .DEPTH(2)) u2 (
    .i_clk(clk), .i_rst(rst), .slave_if(s2), .master_if(m2), .o_idle(idle2)
  );
  rggen_axi4lite_channel_buffer #(.ID_WIDTH(4), .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .DEPTH(3)) u3 (
    .i_clk(clk), .i_rst(rst), .slave_if(s3), .master_if(m3), .o_idle(idle3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample handshakes on the falling edge, then advance past the next rising edge.
  task automatic cycle();
    @(negedge clk);
    if (m2.awvalid && m2.awready) begin
      chk("u2 aw sb nonempty", 64'(q2_aw.size() != 0), 64'd1);
      if (q2_aw.size() != 0) chk("u2 aw order", 64'({m2.awid, m2.awaddr, m2.awprot}), q2_aw.pop_front());
    end
    if (m2.arvalid && m2.arready) begin
      ar2_pops++;
      chk("u2 ar sb nonempty", 64'(q2_ar.size() != 0), 64'd1);
      if (q2_ar.size() != 0) chk("u2 ar order", 64'({m2.arid, m2.araddr, m2.arprot}), q2_ar.pop_front());
    end
    if (m3.awvalid && m3.awready) begin
      chk("u3 aw sb nonempty", 64'(q3_aw.size() != 0), 64'd1);
      if (q3_aw.size() != 0) chk("u3 aw order", 64'({m3.awid, m3.awaddr, m3.awprot}), q3_aw.pop_front());
    end
    if (m3.wvalid && m3.wready) begin
      w3_pops++;
      chk("u3 w sb nonempty", 64'(q3_w.size() != 0), 64'd1);
      if (q3_w.size() != 0) chk("u3 w order", 64'({m3.wdata, m3.wstrb}), q3_w.pop_front());
    end
    if (m3.arvalid && m3.arready) begin
      chk("u3 ar sb nonempty", 64'(q3_ar.size() != 0), 64'd1);
      if (q3_ar.size() != 0) chk("u3 ar order", 64'({m3.arid, m3.araddr, m3.arprot}), q3_ar.pop_front());
    end
    if (!rst) begin
      if (s2.awvalid && s2.awready) q2_aw.push_back(64'({s2.awid, s2.awaddr, s2.awprot}));
      if (s2.arvalid && s2.arready) q2_ar.push_back(64'({s2.arid, s2.araddr, s2.arprot}));
      if (s3.awvalid && s3.awready) q3_aw.push_back(64'({s3.awid, s3.awaddr, s3.awprot}));
      if (s3.wvalid && s3.wready)   q3_w.push_back(64'({s3.wdata, s3.wstrb}));
      if (s3.arvalid && s3.arready) q3_ar.push_back(64'({s3.arid, s3.araddr, s3.arprot}));
    end else begin
      q2_aw.delete(); q2_ar.delete(); q3_aw.delete(); q3_w.delete(); q3_ar.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0; n_err = 0; ar2_pops = 0; w3_pops = 0;
    bp_addr = '{8'h10, 8'h20, 8'h30, 8'h40};
    rst = 1'b1;
    s2.awvalid = 1'b1; s2.awid = '0; s2.awaddr = '0; s2.awprot = '0;
    s2.wvalid = 1'b0; s2.wdata = '0; s2.wstrb = '0; s2.bready = 1'b1;
    s2.arvalid = 1'b0; s2.arid = '0; s2.araddr = '0; s2.arprot = '0; s2.rready = 1'b1;
    m2.awready = 1'b1; m2.wready = 1'b1; m2.bvalid = 1'b0; m2.bid = '0; m2.bresp = '0;
    m2.arready = 1'b1; m2.rvalid = 1'b0; m2.rid = '0; m2.rresp = '0; m2.rdata = '0;
    s3.awvalid = 1'b1; s3.awid = '0; s3.awaddr = '0; s3.awprot = '0;
    s3.wvalid = 1'b0; s3.wdata = '0; s3.wstrb = '0; s3.bready = 1'b1;
    s3.arvalid = 1'b0; s3.arid = '0; s3.araddr = '0; s3.arprot = '0; s3.rready = 1'b1;
    m3.awready = 1'b1; m3.wready = 1'b1; m3.bvalid = 1'b0; m3.bid = '0; m3.bresp = '0;
    m3.arready = 1'b1; m3.rvalid = 1'b0; m3.rid = '0; m3.rresp = '0; m3.rdata = '0;
    @(posedge clk);
    #1;

    // Reset held while the upstream side keeps offering an address.
    for (int r = 0; r < 2; r++) begin
      chk("reset awready", s2.awready, 1'b1);
      chk("reset m awvalid", m2.awvalid, 1'b0);
      chk("reset idle", idle2, 1'b1);
      chk("reset u3 arready", s3.arready, 1'b1);
      chk("reset u3 m wvalid", m3.wvalid, 1'b0);
      cycle();
    end
    rst = 1'b0; s2.awvalid = 1'b0; s3.awvalid = 1'b0;
    for (int r = 0; r < 2; r++) begin
      cycle();
      chk("post reset m awvalid", m2.awvalid, 1'b0);
      chk("post reset idle", idle2, 1'b1);
    end

    // Streaming through the 2-deep AR FIFO.
    m2.arready = 1'b1;
    s2.arvalid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k < 8) begin
        s2.araddr = 8'(k * 4);
        s2.arid = 4'(k);
        chk("stream arready", s2.arready, 1'b1);
      end else begin
        s2.arvalid = 1'b0;
      end
      chk("stream arvalid", m2.arvalid, (k > 0));
      if (k > 0) chk("stream araddr", m2.araddr, 8'((k - 1) * 4));
      cycle();
    end
    chk("stream drained", m2.arvalid, 1'b0);
    chk("stream count", ar2_pops, 8);

    // Backpressure on the 3-deep AW FIFO.
    m3.awready = 1'b0;
    s3.awvalid = 1'b1;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      s3.awaddr = bp_addr[idx];
      chk("bp awready", s3.awready, (idx < 3));
      chk("bp m awvalid", m3.awvalid, (idx > 0));
      if (idx > 0) chk("bp hold payload", m3.awaddr, 8'h10);
      acc = s3.awready;
      cycle();
      if (acc) idx++;
    end
    m3.awready = 1'b1;
    s3.awaddr = bp_addr[3];
    chk("bp still full", s3.awready, 1'b0);
    acc = s3.awready;
    cycle();
    if (acc) idx++;
    chk("bp ready rises", s3.awready, 1'b1);
    acc = s3.awready;
    cycle();
    if (acc) idx++;
    s3.awvalid = 1'b0;
    for (int c = 0; c < 8 && q3_aw.size() != 0; c++) cycle();
    chk("bp accepted", idx, 4);
    chk("bp drained", q3_aw.size(), 0);
    chk("bp idle", idle3, 1'b1);

    // W stream with the downstream ready toggling, wrapping the pointers.
    widx = 0;
    w3_pops = 0;
    for (int c = 0; c < 60 && (widx < 10 || q3_w.size() != 0); c++) begin
      m3.wready = (c % 2 == 0);
      if (widx < 10) begin
        s3.wvalid = 1'b1;
        s3.wdata = 32'hA0 + 32'(widx);
        s3.wstrb = 4'(widx) ^ 4'hF;
      end else begin
        s3.wvalid = 1'b0;
      end
      acc = s3.wvalid && s3.wready;
      cycle();
      if (acc) widx++;
    end
    s3.wvalid = 1'b0;
    m3.wready = 1'b1;
    chk("wrap pushed", widx, 10);
    chk("wrap delivered", w3_pops, 10);

    // AR keeps flowing while AW is stalled.
    m3.awready = 1'b0;
    s3.awvalid = 1'b1; s3.awaddr = 8'h50;
    s3.arvalid = 1'b1; s3.arid = 4'd5; s3.araddr = 8'h44;
    cycle();
    s3.awvalid = 1'b0; s3.arvalid = 1'b0;
    chk("indep arvalid", m3.arvalid, 1'b1);
    chk("indep araddr", m3.araddr, 8'h44);
    chk("indep arid", m3.arid, 4'd5);
    chk("indep awvalid", m3.awvalid, 1'b1);
    chk("indep idle busy", idle3, 1'b0);
    cycle();
    chk("indep ar done", m3.arvalid, 1'b0);
    chk("indep aw held", m3.awaddr, 8'h50);
    chk("indep idle still busy", idle3, 1'b0);
    m3.awready = 1'b1;
    cycle();
    chk("indep idle after drain", idle3, 1'b1);

    // Reset in the middle of buffered traffic.
    m3.awready = 1'b0;
    s3.awvalid = 1'b1; s3.awaddr = 8'h60;
    cycle();
    s3.awaddr = 8'h70;
    cycle();
    s3.awvalid = 1'b0;
    chk("midrst buffered", m3.awvalid, 1'b1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst awvalid", m3.awvalid, 1'b0);
    chk("midrst idle", idle3, 1'b1);
    chk("midrst awready", s3.awready, 1'b1);
    m3.awready = 1'b1;
    cycle();
    cycle();
    chk("midrst nothing emitted", m3.awvalid, 1'b0);

    // Response path: pass-through or one registered stage.
    s3.bready = 1'b0;
    #1;
`ifdef RGGEN_AXI4LITE_RESPONSE_SLICE_EN
    chk("resp bready", m3.bready, 1'b1);
`else
    chk("resp bready", m3.bready, 1'b0);
`endif
    s3.bready = 1'b1;
    m3.rvalid = 1'b1; m3.rdata = 32'hDEADBEEF; m3.rresp = 2'd2; m3.rid = 4'd3;
    #1;
`ifdef RGGEN_AXI4LITE_RESPONSE_SLICE_EN
    chk("resp rvalid at N", s3.rvalid, 1'b0);
    cycle();
    m3.rvalid = 1'b0;
    #1;
`endif
    chk("resp rvalid", s3.rvalid, 1'b1);
    chk("resp rdata", s3.rdata, 32'hDEADBEEF);
    chk("resp rresp", s3.rresp, 2'd2);
    chk("resp rid", s3.rid, 4'd3);
    cycle();
    m3.rvalid = 1'b0;
    #1;
    chk("resp rvalid end", s3.rvalid, 1'b0);

    chk("final q2 empty", q2_aw.size() + q2_ar.size(), 0);
    chk("final q3 empty", q3_aw.size() + q3_w.size() + q3_ar.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
